// File: rtl/seq_divider_unsigned.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes on the start edge.
module seq_divider_unsigned #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one restoring iteration per clock
    // DONE  | result valid, done=1 for this cycle
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state, state_next;
    logic [WIDTH:0]   rem, rem_next, shifted, trial;
    logic [WIDTH-1:0] quo, quo_next, div;
    logic [CW-1:0]    cnt;
    logic             accept, last_iter, zero_fast;

    assign accept    = (state != RUN) && start;
    assign last_iter = (state == RUN) && (cnt == CW'(1));

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (Y == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // The remainder never exceeds the divisor, so its low WIDTH bits plus the
    // incoming dividend bit always fit in WIDTH+1 bits.
    always_comb begin
        shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = shifted - {1'b0, div};
        if (!trial[WIDTH]) begin
            rem_next = trial;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted;
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start)              state_next = zero_fast ? DONE : RUN;
                else if (state == DONE) state_next = IDLE;
            end
            RUN: if (cnt == CW'(1)) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            quo         <= '0;
            div         <= '0;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem <= '0;
            quo <= X;
            div <= Y;
            cnt <= CW'(WIDTH);
            if (zero_fast) begin
                Q           <= '1;
                R           <= X;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt - CW'(1);
            if (last_iter) begin
                Q           <= quo_next;
                R           <= rem_next[WIDTH-1:0];
                div_by_zero <= (div == '0);
            end
        end
    end
endmodule

// File: tb/tb_seq_divider_unsigned.sv
// Directed and random checks for seq_divider_unsigned (WIDTH=8); honours DIV_ZERO_FAST_EN.
module tb_seq_divider_unsigned;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] X = '0;
    logic [7:0] Y = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] Q, R;

    int n_cmp = 0;
    int n_err = 0;
    int lat, bc;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 0;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT = 8;
    localparam int ZBUSY = 8;
`endif

    seq_divider_unsigned #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
        .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive a request so it is sampled at the next rising edge (edge k).
    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1; X = x; Y = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges after edge k until done, and busy cycles seen along the way.
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = busy ? 1 : 0;
        while (!done && l < 20) begin
            @(posedge clk);
            #1;
            l++;
            if (busy) b++;
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                           input logic ez);
        issue(x, y);
        wait_done(lat, bc);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_q"}, Q, eq);
        check({tag, "_r"}, R, er);
        check({tag, "_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        int dones;
        logic [7:0] rx, ry;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk) rst_n = 1'b1;

        run_div("d200_7", 8'd200, 8'd7, 8, 8'd28, 8'd4, 1'b0);
        check("d200_7_busy", bc, 8);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("hold_q_idle", Q, 28);

        run_div("d255_1", 8'd255, 8'd1, 8, 8'd255, 8'd0, 1'b0);
        run_div("d5_9", 8'd5, 8'd9, 8, 8'd0, 8'd5, 1'b0);
        run_div("d255_255", 8'd255, 8'd255, 8, 8'd1, 8'd0, 1'b0);
        run_div("d0_13", 8'd0, 8'd13, 8, 8'd0, 8'd0, 1'b0);
        run_div("dz100", 8'd100, 8'd0, ZLAT, 8'hFF, 8'd100, 1'b1);
        check("dz_busy", bc, ZBUSY);
        run_div("d17_5_after_dz", 8'd17, 8'd5, 8, 8'd3, 8'd2, 1'b0);

        // start during RUN must be ignored
        issue(8'd200, 8'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; X = 8'd9; Y = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("ign_lat", lat + 3, 8);
        check("ign_q", Q, 28);
        check("ign_r", R, 4);

        // back-to-back: start in the DONE cycle
        issue(8'd9, 8'd3);
        check("b2b_done_drop", done, 0);
        check("b2b_busy", busy, 1);
        check("b2b_hold_q", Q, 28);
        check("b2b_hold_r", R, 4);
        wait_done(lat, bc);
        check("b2b_lat", lat, 8);
        check("b2b_q", Q, 3);
        check("b2b_r", R, 0);

        // asynchronous reset mid-run
        issue(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_q", Q, 0);
        check("mrst_r", R, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("mrst_no_done", dones, 0);

        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(1, 255));
            issue(rx, ry);
            wait_done(lat, bc);
            check("rnd_lat", lat, 8);
            check("rnd_q", Q, rx / ry);
            check("rnd_r", R, rx % ry);
            check("rnd_recon", 32'(Q) * 32'(ry) + 32'(R), 32'(rx));
            check("rnd_r_lt_y", (R < ry) ? 1 : 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
